// File: rtl/control_decoder_pkg.sv
// Shared constants for the instruction control decoder.
//   - opcode-independent funct codes for R-type ALU instructions
//   - bit positions of the 17-bit control field in the control word
//   - ALU class encodings
//   - packed layout of the 32-bit control word
package control_decoder_pkg;

  // R-type funct codes
  localparam logic [5:0] FunctAdd = 6'd32;
  localparam logic [5:0] FunctSub = 6'd34;
  localparam logic [5:0] FunctMul = 6'd50;
  localparam logic [5:0] FunctNop = 6'd63;

  // Control-bit positions within the 17-bit control field
  localparam int unsigned BitAluSrc    = 16;
  localparam int unsigned BitAluClsHi  = 15;
  localparam int unsigned BitAluClsLo  = 13;
  localparam int unsigned BitMemWrite  = 12;
  localparam int unsigned BitMemEnable = 11;
  localparam int unsigned BitMemToReg  = 10;
  localparam int unsigned BitAluWb     = 9;
  localparam int unsigned BitSubtract  = 8;

  typedef enum logic [2:0] {
    AluAddSub = 3'b000,
    AluMul    = 3'b001
  } alu_class_e;

  // Control word layout: [31:27] A, [26:22] B, [21:17] write reg, [16:0] control bits
  typedef struct packed {
    logic [4:0]  reg_a;
    logic [4:0]  reg_b;
    logic [4:0]  reg_wr;
    logic [16:0] ctrl;
  } control_word_t;

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decoder.
//   instruction  : 32-bit instruction word
//   control_word : decoded 32-bit control word (unregistered)
// Optional feature: define CONTROL_MUL_EN to decode R-type funct 50 as multiply;
// otherwise funct 50 is an unknown funct and decodes to all zeros.
module control_decode
  import control_decoder_pkg::*;
#(
  parameter logic [5:0] OP_RTYPE = 6'd9,
  parameter logic [5:0] OP_LOAD  = 6'd10,
  parameter logic [5:0] OP_STORE = 6'd11
) (
  input  logic [31:0] instruction,
  output logic [31:0] control_word
);

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [5:0] funct;
  control_word_t word;

  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign funct  = instruction[5:0];

  // shamt plays no part in decoding
  logic unused_shamt;
  assign unused_shamt = ^instruction[10:6];

  always_comb begin
    word = '0;
    case (opcode)
      OP_LOAD: begin
        word.reg_a                = rs;
        word.reg_wr               = rt;
        word.ctrl[BitAluSrc]      = 1'b1;
        word.ctrl[BitMemEnable]   = 1'b1;
        word.ctrl[BitMemToReg]    = 1'b1;
      end
      OP_STORE: begin
        word.reg_a                = rs;
        word.reg_b                = rt;
        word.ctrl[BitAluSrc]      = 1'b1;
        word.ctrl[BitMemWrite]    = 1'b1;
        word.ctrl[BitMemEnable]   = 1'b1;
      end
      OP_RTYPE: begin
        unique case (funct)
          FunctAdd: begin
            word.reg_a              = rs;
            word.reg_b              = rt;
            word.reg_wr             = rd;
            word.ctrl[BitAluWb]     = 1'b1;
          end
          FunctSub: begin
            word.reg_a              = rs;
            word.reg_b              = rt;
            word.reg_wr             = rd;
            word.ctrl[BitAluWb]     = 1'b1;
            word.ctrl[BitSubtract]  = 1'b1;
          end
`ifdef CONTROL_MUL_EN
          FunctMul: begin
            word.reg_a              = rs;
            word.reg_b              = rt;
            word.reg_wr             = rd;
            word.ctrl[BitAluClsHi:BitAluClsLo] = AluMul;
            word.ctrl[BitAluWb]     = 1'b1;
          end
`endif
          // nop and unknown funct codes leave the word all zeros
          default: word = '0;
        endcase
      end
      default: word = '0;
    endcase
  end

  assign control_word = word;

endmodule

// File: rtl/control_decoder.sv
// Registered instruction control decoder.
//   clk          : clock, state updates on the rising edge
//   rst_n        : synchronous active-low reset, clears control_out
//   instruction  : 32-bit instruction word, sampled every rising edge
//   control_out  : control word for the instruction sampled at the previous edge
// Optional feature: define CONTROL_MUL_EN to enable multiply decode (funct 50).
module control_decoder
  import control_decoder_pkg::*;
#(
  parameter logic [5:0] OP_RTYPE = 6'd9,
  parameter logic [5:0] OP_LOAD  = 6'd10,
  parameter logic [5:0] OP_STORE = 6'd11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic [31:0] control_out
);

  logic [31:0] control_d;
  logic [31:0] control_q;

  control_decode #(
    .OP_RTYPE (OP_RTYPE),
    .OP_LOAD  (OP_LOAD),
    .OP_STORE (OP_STORE)
  ) u_decode (
    .instruction  (instruction),
    .control_word (control_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      control_q <= '0;
    end else begin
      control_q <= control_d;
    end
  end

  assign control_out = control_q;

endmodule

// File: tb/tb_control_decoder.sv
// Directed self-checking bench for control_decoder.
module tb_control_decoder;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic [31:0] control_out;

  int unsigned n_vec;
  int unsigned n_fail;

  control_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .control_out (control_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] exp);
    n_vec++;
    assert (control_out === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, control_out, exp);
    end
  endtask

  // Drive an instruction right after an edge, confirm the output still holds the
  // previous word, then check the new word after the next edge.
  task automatic step(input string tag, input logic [31:0] instr,
                      input logic [31:0] prev, input logic [31:0] exp);
    instruction = instr;
    #2;
    check({tag, "_hold"}, prev);
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  localparam logic [31:0] WLoad  = 32'h0003_0C00;
  localparam logic [31:0] WSub   = 32'h190C_0300;
  localparam logic [31:0] WAdd   = 32'h0886_0200;
  localparam logic [31:0] WStore = 32'h39C1_1800;
`ifdef CONTROL_MUL_EN
  localparam logic [31:0] WMul   = 32'h298E_2200;
`else
  localparam logic [31:0] WMul   = 32'h0000_0000;
`endif

  initial begin
    n_vec       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    instruction = {6'd10, 5'd0, 5'd1, 16'h1DD0};

    // Reset held for two cycles with a valid load on the bus
    @(posedge clk);
    #1;
    check("reset_c1", 32'h0);
    @(posedge clk);
    #1;
    check("reset_c2", 32'h0);

    // First decode at the first edge with rst_n high
    rst_n = 1'b1;
    #2;
    check("reset_release_hold", 32'h0);
    @(posedge clk);
    #1;
    check("load", WLoad);

    step("sub",      {6'd9, 5'd3, 5'd4, 5'd6, 5'd10, 6'd34}, WLoad, WSub);
    step("mul",      {6'd9, 5'd5, 5'd6, 5'd7, 5'd10, 6'd50}, WSub,  WMul);
    step("store",    {6'd11, 5'd7, 5'd7, 16'h21CF},          WMul,  WStore);
    step("add",      {6'd9, 5'd1, 5'd2, 5'd3, 5'd31, 6'd32}, WStore, WAdd);
    step("nop",      {6'd9, 5'd1, 5'd2, 5'd3, 5'd0, 6'd63},  WAdd,  32'h0);
    step("op0",      {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd32},  32'h0, 32'h0);
    step("add_b2b",  {6'd9, 5'd1, 5'd2, 5'd3, 5'd0, 6'd32},  32'h0, WAdd);
    step("badfunct", {6'd9, 5'd1, 5'd2, 5'd3, 5'd0, 6'd33},  WAdd,  32'h0);
    step("load_b2b", {6'd10, 5'd0, 5'd1, 16'h1DD0},          32'h0, WLoad);
    step("store_b2b",{6'd11, 5'd7, 5'd7, 16'h21CF},          WLoad, WStore);
    step("badop",    {6'd12, 5'd7, 5'd7, 16'h21CF},          WStore, 32'h0);
    step("sub_b2b",  {6'd9, 5'd3, 5'd4, 5'd6, 5'd0, 6'd34},  32'h0, WSub);

    // Reset mid-stream overrides a valid instruction
    rst_n       = 1'b0;
    instruction = {6'd11, 5'd7, 5'd7, 16'h21CF};
    @(posedge clk);
    #1;
    check("reset_mid", 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_reset_store", WStore);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
